// File: rtl/instr_loader_if.sv
// Button, switch and execute-handshake signals between the loader and its surroundings.
// slave is the loader's view; master is the board/execute-controller side.
interface instr_loader_if;
  logic        btn_raw;
  logic [7:0]  sw;
  logic        exec_busy;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done;
  logic        btn_edge;
  logic [1:0]  load_state;

  modport master (
    output btn_raw, sw, exec_busy,
    input  opcode, instr, inst_done, btn_edge, load_state
  );

  modport slave (
    input  btn_raw, sw, exec_busy,
    output opcode, instr, inst_done, btn_edge, load_state
  );
endinterface

// File: rtl/instr_loader.sv
// Loads a 16-bit instruction word from two button-strobed switch bytes, then fires one run pulse.
// Debounce counter present only when LOADER_DEBOUNCE_EN is defined; otherwise press latency is 2 cycles.
module instr_loader #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rstn,
  instr_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_WAIT_LO = 2'd0,
    S_WAIT_HI = 2'd1,
    S_READY   = 2'd2,
    S_RUN     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic        seen_busy_q, seen_busy_d;
  logic        sync1_q, sync2_q;
  logic        db;
  logic        db_dly_q;
  logic        press;
  logic        btn_edge;
  logic        inst_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef LOADER_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        db_q, db_d;

  // Level flips only after the input has disagreed for DEBOUNCE_CYCLES straight cycles.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == DB_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db = db_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign db = sync2_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_dly_q <= 1'b0;
    end else begin
      db_dly_q <= db;
    end
  end

  assign press = db & ~db_dly_q;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    seen_busy_d = seen_busy_q;
    btn_edge    = 1'b0;
    inst_done   = 1'b0;
    case (state_q)
      S_WAIT_LO: begin
        if (press) begin
          word_d[7:0] = bus.sw;
          state_d     = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (press) begin
          word_d[15:8] = bus.sw;
          state_d      = S_READY;
        end
      end
      S_READY: begin
        inst_done = 1'b1;
        if (press) begin
          btn_edge    = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        inst_done = 1'b1;
        // Only a busy-then-idle sequence ends the run; an idle controller at entry is not enough.
        if (seen_busy_q && !bus.exec_busy) begin
          seen_busy_d = 1'b0;
          state_d     = S_WAIT_LO;
        end else if (bus.exec_busy) begin
          seen_busy_d = 1'b1;
        end
      end
      default: state_d = S_WAIT_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_WAIT_LO;
      word_q      <= '0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      seen_busy_q <= seen_busy_d;
    end
  end

  assign bus.opcode     = word_q[3:0];
  assign bus.instr      = word_q[15:4];
  assign bus.inst_done  = inst_done;
  assign bus.btn_edge   = btn_edge;
  assign bus.load_state = state_q;

endmodule
